l2_arbiter_rr: RTL and testbench

//  Parametrised N-channel round-robin arbiter for cacheline (LINE_W-bit) requests.

---
 rtl/l2_arbiter_rr.sv | 98 +++++++++
 tb/tb_l2_arbiter_rr.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_arbiter_rr.sv
// l2_arbiter_rr: round-robin arbiter serialising NUM_CH cacheline requesters onto one memory port.
// Define ARB_FIXED_PRIO0_EN to give channel 0 absolute priority over the rotating others.
module l2_arbiter_rr #(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH*ADDR_W-1:0] ch_address,
  input  logic [NUM_CH*LINE_W-1:0] ch_wdata,
  input  logic [NUM_CH-1:0]        ch_read,
  input  logic [NUM_CH-1:0]        ch_write,
  output logic [LINE_W-1:0]        ch_rdata,
  output logic [NUM_CH-1:0]        ch_resp,
  output logic [ADDR_W-1:0]        mem_address,
  output logic [LINE_W-1:0]        mem_wdata,
  output logic                     mem_read,
  output logic                     mem_write,
  input  logic                     mem_resp,
  input  logic [LINE_W-1:0]        mem_rdata,
  output logic                     busy
);
  localparam int ID_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  localparam int OFF_W = $clog2(LINE_W / 8);
  localparam logic [ADDR_W-1:0] MASK = ~ADDR_W'((2 ** OFF_W) - 1);
`ifdef ARB_FIXED_PRIO0_EN
  localparam bit PRIO0 = 1'b1;
`else
  localparam bit PRIO0 = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;
  state_e              state_q;
  logic [ID_W-1:0]     last_q, g_q, g_d;
  logic                found, rd_q, wr_q;
  logic [NUM_CH-1:0]   req, resp_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [LINE_W-1:0]   wdata_q, rdata_q;
  assign req = ch_read | ch_write;
  // Scan from the channel after the last winner; channel 0 is pre-empted when it has priority.
  always_comb begin
    int c;
    c = 0;
    g_d = '0;
    found = PRIO0 && req[0];
    for (int k = 1; k <= NUM_CH; k++) begin
      c = (int'(last_q) + k) % NUM_CH;
      if (!found && req[c] && !(PRIO0 && c == 0)) begin
        g_d = ID_W'(c);
        found = 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= ID_W'(NUM_CH - 1);
      g_q     <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      resp_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (found) begin
          state_q <= BUSY;
          g_q     <= g_d;
          rd_q    <= ~ch_write[g_d];
          wr_q    <= ch_write[g_d];
          addr_q  <= ch_address[g_d*ADDR_W +: ADDR_W] & MASK;
          wdata_q <= ch_wdata[g_d*LINE_W +: LINE_W];
          if (!(PRIO0 && g_d == '0)) last_q <= g_d;
        end
        BUSY: if (mem_resp) begin
          state_q <= RESP;
          rd_q    <= 1'b0;
          wr_q    <= 1'b0;
          rdata_q <= mem_rdata;
          resp_q  <= NUM_CH'(1) << g_q;
        end
        RESP: begin
          state_q <= IDLE;
          resp_q  <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign mem_read    = rd_q;
  assign mem_write   = wr_q;
  assign mem_address = addr_q;
  assign mem_wdata   = wdata_q;
  assign ch_resp     = resp_q;
  assign ch_rdata    = rdata_q;
  assign busy        = state_q != IDLE;
endmodule

// File: tb/tb_l2_arbiter_rr.sv
// tb_l2_arbiter_rr: randomized bench for l2_arbiter_rr with a round-robin reference model.
module tb_l2_arbiter_rr;
  localparam int N = 3, AW = 32, LW = 256;
  logic clk = 1'b0, rst;
  logic [N*AW-1:0] ch_address;
  logic [N*LW-1:0] ch_wdata;
  logic [N-1:0] ch_read, ch_write, ch_resp;
  logic [LW-1:0] ch_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_address;
  logic mem_read, mem_write, mem_resp, busy;
  int checks = 0, errors = 0, m_last = N - 1;

  l2_arbiter_rr #(.NUM_CH(N), .ADDR_W(AW), .LINE_W(LW)) dut (
    .clk(clk), .rst(rst), .ch_address(ch_address), .ch_wdata(ch_wdata),
    .ch_read(ch_read), .ch_write(ch_write), .ch_rdata(ch_rdata), .ch_resp(ch_resp),
    .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_read(mem_read),
    .mem_write(mem_write), .mem_resp(mem_resp), .mem_rdata(mem_rdata), .busy(busy));

  always #5 clk = ~clk;

  function automatic logic [LW-1:0] rnd_line();
    logic [LW-1:0] r;
    for (int i = 0; i < LW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Reference: first requester at distance 1..N after the previous winner.
  function automatic int pick(input logic [N-1:0] req);
`ifdef ARB_FIXED_PRIO0_EN
    if (req[0]) return 0;
`endif
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (m_last + k) % N;
`ifdef ARB_FIXED_PRIO0_EN
      if (c == 0) continue;
`endif
      if (req[c]) return c;
    end
    return -1;
  endfunction

  task automatic scramble();
    for (int c = 0; c < N; c++) begin
      ch_address[c*AW +: AW] = $urandom;
      ch_wdata[c*LW +: LW] = rnd_line();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; ch_read = '0; ch_write = '0; mem_resp = 1'b0; mem_rdata = '0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    m_last = N - 1;
  endtask

  // Runs one transaction starting in an IDLE cycle; returns the expected winner.
  task automatic serve(input bit drop, input int delay, input logic [LW-1:0] line, output int g);
    logic rw;
    logic [AW-1:0] ea;
    logic [LW-1:0] ew;
    g = pick(ch_read | ch_write);
    if (g < 0) begin
      errors++;
      $display("FAIL serve_setup: no requester, got %0d want >=0", g);
      return;
    end
    rw = ch_write[g];
    ea = ch_address[g*AW +: AW] & 32'hFFFF_FFE0;
    ew = ch_wdata[g*LW +: LW];
`ifdef ARB_FIXED_PRIO0_EN
    if (g != 0) m_last = g;
`else
    m_last = g;
`endif
    @(posedge clk); #1;
    checks++;
    if ({mem_read, mem_write, busy, ch_resp} !== {~rw, rw, 1'b1, 3'b000}) begin
      errors++;
      $display("FAIL issue_ctrl: got r%b w%b b%b resp%b want r%b w%b b1 resp000 (ch%0d)",
               mem_read, mem_write, busy, ch_resp, ~rw, rw, g);
    end
    checks++;
    if (mem_address !== ea) begin
      errors++;
      $display("FAIL issue_addr: got %h want %h", mem_address, ea);
    end
    checks++;
    if (mem_wdata !== ew) begin
      errors++;
      $display("FAIL issue_wdata: got %h want %h", mem_wdata, ew);
    end
    if (drop) begin ch_read[g] = 1'b0; ch_write[g] = 1'b0; end
    scramble();
    repeat (delay) begin
      @(posedge clk); #1;
      checks++;
      if ({mem_read, mem_write, ch_resp, mem_address} !== {~rw, rw, 3'b000, ea}) begin
        errors++;
        $display("FAIL busy_hold: got r%b w%b resp%b a%h want r%b w%b resp000 a%h",
                 mem_read, mem_write, ch_resp, mem_address, ~rw, rw, ea);
      end
    end
    mem_resp = 1'b1; mem_rdata = line;
    @(posedge clk); #1;
    mem_resp = 1'b0; mem_rdata = rnd_line();
    checks++;
    if ({ch_resp, mem_read, mem_write, busy} !== {3'b001 << g, 3'b001}) begin
      errors++;
      $display("FAIL resp_pulse: got resp%b r%b w%b b%b want resp%b r0 w0 b1",
               ch_resp, mem_read, mem_write, busy, 3'b001 << g);
    end
    checks++;
    if (ch_rdata !== line) begin
      errors++;
      $display("FAIL resp_rdata: got %h want %h", ch_rdata, line);
    end
    @(posedge clk); #1;
    checks++;
    if ({ch_resp, busy, mem_read, mem_write} !== 6'b0) begin
      errors++;
      $display("FAIL back_idle: got resp%b b%b r%b w%b want all 0", ch_resp, busy, mem_read, mem_write);
    end
  endtask

  task automatic test_reset();
    ch_address = '0; ch_wdata = '0;
    do_reset();
    checks++;
    if ({mem_read, mem_write, busy, ch_resp, mem_address, mem_wdata, ch_rdata} !== '0) begin
      errors++;
      $display("FAIL reset_state: got r%b w%b b%b resp%b a%h want all 0", mem_read, mem_write, busy, ch_resp, mem_address);
    end
  endtask

  task automatic test_idle_resp();
    mem_resp = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      checks++;
      if ({busy, ch_resp, mem_read, mem_write} !== 6'b0) begin
        errors++;
        $display("FAIL idle_ignore: got b%b resp%b r%b w%b want all 0", busy, ch_resp, mem_read, mem_write);
      end
    end
    mem_resp = 1'b0;
  endtask

  task automatic test_single_read();
    int g;
    ch_address[0 +: AW] = 32'h0000_1234;
    ch_read = 3'b001;
    serve(1'b0, 2, {32{8'hA5}}, g);
    ch_read = '0;
    checks++;
    if (g != 0) begin
      errors++;
      $display("FAIL single_grant: got %0d want 0", g);
    end
  endtask

  task automatic test_alternate();
    int g, prev = -1;
    do_reset();
    ch_read = 3'b011;
    for (int i = 0; i < 4; i++) begin
      serve(1'b0, i % 3, rnd_line(), g);
`ifndef ARB_FIXED_PRIO0_EN
      checks++;
      if (g == prev || g != i % 2) begin
        errors++;
        $display("FAIL alternate: got %0d want %0d", g, i % 2);
      end
`endif
      prev = g;
    end
    ch_read = '0;
  endtask

  task automatic test_three_writes();
    int g;
    do_reset();
    ch_write = 3'b111;
    for (int i = 0; i < 6; i++) begin
      serve(1'b0, 1, rnd_line(), g);
`ifndef ARB_FIXED_PRIO0_EN
      checks++;
      if (g != i % 3) begin
        errors++;
        $display("FAIL rotate3: got %0d want %0d", g, i % 3);
      end
`endif
    end
    ch_write = '0;
  endtask

  task automatic test_rw_and_drop();
    int g;
    ch_read = 3'b010; ch_write = 3'b010;
    ch_wdata[LW +: LW] = {LW{1'b1}};
    serve(1'b0, 1, rnd_line(), g);
    ch_read = 3'b001; ch_write = '0;
    serve(1'b1, 2, rnd_line(), g);
    ch_read = '0;
  endtask

  task automatic test_reset_busy();
    int g;
    ch_read = 3'b100;
    @(posedge clk); #1;
    checks++;
    if ({busy, mem_read} !== 2'b11) begin
      errors++;
      $display("FAIL pre_reset_busy: got b%b r%b want b1 r1", busy, mem_read);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_last = N - 1;
    checks++;
    if ({mem_read, mem_write, busy, ch_resp} !== 6'b0) begin
      errors++;
      $display("FAIL mid_reset: got r%b w%b b%b resp%b want all 0", mem_read, mem_write, busy, ch_resp);
    end
    ch_read = 3'b111;
    serve(1'b0, 0, rnd_line(), g);
    ch_read = '0;
    checks++;
    if (g != 0) begin
      errors++;
      $display("FAIL post_reset_grant: got %0d want 0", g);
    end
  endtask

  task automatic test_prio();
    int g;
    do_reset();
    ch_read = 3'b111;
    for (int i = 0; i < 3; i++) serve(1'b0, 0, rnd_line(), g);
    ch_read = 3'b110;
    for (int i = 0; i < 4; i++) serve(1'b0, 1, rnd_line(), g);
    ch_read = '0;
  endtask

  task automatic test_random();
    int g;
    for (int i = 0; i < 40; i++) begin
      ch_read = 3'($urandom);
      ch_write = 3'($urandom);
      if ((ch_read | ch_write) == 3'b000) ch_read = 3'b100;
      serve(1'($urandom), int'($urandom_range(0, 3)), rnd_line(), g);
    end
    ch_read = '0; ch_write = '0;
  endtask

  initial begin
    rst = 1'b1; mem_resp = 1'b0; mem_rdata = '0; ch_read = '0; ch_write = '0;
    test_reset();
    test_idle_resp();
    test_single_read();
    test_alternate();
    test_three_writes();
    test_rw_and_drop();
    test_reset_busy();
    test_prio();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
